// File: rtl/simple_bus_arb_mem_if.sv
// simple_bus_arb_mem_if: bundled request/grant and command/data signals
// shared between NCH simple_bus masters and the arbitrated memory slave.
// The master modport is the CPU side and the slave modport is the memory block.
interface simple_bus_arb_mem_if #(
  parameter int NCH = 2,
  parameter int AW  = 8,
  parameter int DW  = 8
) ();

  logic [NCH-1:0]    req;
  logic [NCH-1:0]    gnt;
  logic [NCH-1:0]    start;
  logic [NCH*AW-1:0] addr;
  logic [NCH*2-1:0]  mode;
  logic [NCH*DW-1:0] wdata;
  logic [NCH-1:0]    rdy;
  logic [DW-1:0]     rdata;
  logic              busy;
  logic              err;

  modport master (
    output req,
    output start,
    output addr,
    output mode,
    output wdata,
    input  gnt,
    input  rdy,
    input  rdata,
    input  busy,
    input  err
  );

  modport slave (
    input  req,
    input  start,
    input  addr,
    input  mode,
    input  wdata,
    output gnt,
    output rdy,
    output rdata,
    output busy,
    output err
  );

endinterface

// File: rtl/simple_bus_arb_mem.sv
// simple_bus_arb_mem: round-robin arbiter in front of a DEPTH x DW memory.
// One master at a time holds gnt and issues single-beat or incrementing
// burst reads/writes. A beat completes every cycle the block is in ACCESS.
// Optional idle-grant watchdog: define SIMPLE_BUS_ARB_TIMEOUT_EN.
module simple_bus_arb_mem #(
  parameter int NCH       = 2,
  parameter int AW        = 8,
  parameter int DW        = 8,
  parameter int BURST_LEN = 4,
  parameter int TIMEOUT   = 16
) (
  input logic                clk,
  input logic                rst,
  simple_bus_arb_mem_if.slave bus
);

  localparam int DEPTH = 2 ** AW;
  localparam int IW    = (NCH > 1) ? $clog2(NCH) : 1;
  localparam int BW    = $clog2(BURST_LEN + 1);

  localparam logic [1:0] IDLE    = 2'd0;
  localparam logic [1:0] GRANT   = 2'd1;
  localparam logic [1:0] ACCESS  = 2'd2;
  localparam logic [1:0] RELEASE = 2'd3;

  logic [1:0]     r_state;
  logic [NCH-1:0] r_gnt;
  logic [IW-1:0]  r_owner;
  logic [IW-1:0]  r_rrPtr;
  logic [AW-1:0]  r_curAddr;
  logic           r_write;
  logic [BW-1:0]  r_beatsLeft;
  logic [DW-1:0]  r_rdata;
  logic [DW-1:0]  r_mem [DEPTH];

  logic           w_anyReq;
  logic [IW-1:0]  w_pickIdx;
  logic [IW-1:0]  w_nextPtr;
  logic           w_ownerReq;
  logic           w_ownerStart;
  logic [AW-1:0]  w_ownerAddr;
  logic [1:0]     w_ownerMode;
  logic [DW-1:0]  w_ownerWdata;
  logic           w_access;
  logic           w_readBeat;
  logic           w_wdExpire;

  // Only the current owner's command lanes matter; everything else is ignored.
  assign w_ownerReq   = bus.req[r_owner];
  assign w_ownerStart = bus.start[r_owner];
  assign w_ownerAddr  = bus.addr[r_owner*AW +: AW];
  assign w_ownerMode  = bus.mode[r_owner*2 +: 2];
  assign w_ownerWdata = bus.wdata[r_owner*DW +: DW];

  assign w_access   = (r_state == ACCESS);
  assign w_readBeat = w_access && !r_write;

  // Pointer handed to the channel after the one releasing, wrapping at NCH.
  assign w_nextPtr = (r_owner == IW'(NCH - 1)) ? '0 : r_owner + 1'b1;

  // Round-robin pick: the first requester at or after the pointer wins.
  // Scanning from the farthest offset down lets the nearest one overwrite.
  always_comb begin : p_pick
    int idx;
    idx       = 0;
    w_anyReq  = 1'b0;
    w_pickIdx = '0;
    for (int k = NCH - 1; k >= 0; k--) begin
      idx = (int'(r_rrPtr) + k) % NCH;
      if (bus.req[idx]) begin
        w_anyReq  = 1'b1;
        w_pickIdx = IW'(idx);
      end
    end
  end

  // Main controller: grant selection, command capture, beat sequencing and
  // hand-back of the bus. A burst always runs to completion once started.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_gnt       <= '0;
      r_owner     <= '0;
      r_rrPtr     <= '0;
      r_curAddr   <= '0;
      r_write     <= 1'b0;
      r_beatsLeft <= '0;
      r_rdata     <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_anyReq) begin
            r_owner <= w_pickIdx;
            r_gnt   <= NCH'(1) << w_pickIdx;
            r_state <= GRANT;
          end
        end
        GRANT: begin
          if (w_ownerStart) begin
            r_curAddr   <= w_ownerAddr;
            r_write     <= w_ownerMode[0];
            r_beatsLeft <= w_ownerMode[1] ? BW'(BURST_LEN) : BW'(1);
            r_state     <= ACCESS;
          end else if (!w_ownerReq || w_wdExpire) begin
            r_gnt   <= '0;
            r_state <= RELEASE;
          end
        end
        ACCESS: begin
          if (!r_write) begin
            r_rdata <= r_mem[r_curAddr];
          end
          r_curAddr   <= r_curAddr + 1'b1;
          r_beatsLeft <= r_beatsLeft - 1'b1;
          if (r_beatsLeft == BW'(1)) begin
            r_state <= GRANT;
          end
        end
        RELEASE: begin
          r_gnt   <= '0;
          r_rrPtr <= w_nextPtr;
          r_state <= IDLE;
        end
        default: begin
          r_state <= IDLE;
        end
      endcase
    end
  end

  // Storage write port. Reset blocks the beat in flight so an aborted burst
  // keeps exactly the beats that completed before reset.
  always_ff @(posedge clk) begin
    if (!rst && w_access && r_write) begin
      r_mem[r_curAddr] <= w_ownerWdata;
    end
  end

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] r_wdCount;
  logic          r_err;

  // The owner has sat in GRANT for TIMEOUT cycles without issuing a command.
  assign w_wdExpire = (r_state == GRANT) && !w_ownerStart && w_ownerReq &&
                      (r_wdCount == CW'(TIMEOUT - 1));

  // Idle-grant watchdog: counts GRANT cycles without start, clears on any
  // start or exit from GRANT, and flags a one-cycle err on revoke.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wdCount <= '0;
      r_err     <= 1'b0;
    end else begin
      r_err <= w_wdExpire;
      if ((r_state == GRANT) && !w_ownerStart && !w_wdExpire) begin
        r_wdCount <= r_wdCount + 1'b1;
      end else begin
        r_wdCount <= '0;
      end
    end
  end

  assign bus.err = r_err;
`else
  logic [31:0] w_unusedTimeout;

  // Without the watchdog a grant is held for as long as the owner requests.
  assign w_wdExpire      = 1'b0;
  assign w_unusedTimeout = 32'(TIMEOUT);
  assign bus.err         = 1'b0;
`endif

  // rdy is the owner's one-hot grant during every ACCESS beat. Read data is
  // forwarded straight from storage on read beats and held otherwise.
  assign bus.gnt   = r_gnt;
  assign bus.busy  = (r_state != IDLE);
  assign bus.rdy   = w_access ? r_gnt : '0;
  assign bus.rdata = w_readBeat ? r_mem[r_curAddr] : r_rdata;

endmodule

// File: tb/tb_simple_bus_arb_mem.sv
// tb_simple_bus_arb_mem: scenario tasks for the arbitrated memory, checked
// against a behavioural model (array memory plus a round-robin pointer).
module tb_simple_bus_arb_mem;

  localparam int NCH       = 2;
  localparam int AW        = 8;
  localparam int DW        = 8;
  localparam int BURST_LEN = 4;
  localparam int TIMEOUT   = 16;
  localparam int DEPTH     = 2 ** AW;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  simple_bus_arb_mem_if #(.NCH(NCH), .AW(AW), .DW(DW)) bus ();

  simple_bus_arb_mem #(
    .NCH(NCH), .AW(AW), .DW(DW), .BURST_LEN(BURST_LEN), .TIMEOUT(TIMEOUT)
  ) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  logic [DW-1:0] memModel [DEPTH];
  bit            memKnown [DEPTH];
  int            rrModel;
  int            nChecks = 0;
  int            nFails  = 0;
  logic [DW-1:0] wBuf [16];
  logic [DW-1:0] rBuf [16];

  // Channel the round-robin rule says wins for a given request set.
  function automatic int expectedWinner(input logic [NCH-1:0] reqs);
    for (int k = 0; k < NCH; k++) begin
      if (reqs[(rrModel + k) % NCH]) return (rrModel + k) % NCH;
    end
    return 0;
  endfunction

  function automatic logic [NCH-1:0] oneHot(input int ch);
    return NCH'(1) << ch;
  endfunction

  task automatic modelWrite(input logic [AW-1:0] a, input logic [DW-1:0] d);
    memModel[a] = d;
    memKnown[a] = 1'b1;
  endtask

  task automatic clearInputs();
    bus.req   = '0;
    bus.start = '0;
    bus.addr  = '0;
    bus.mode  = '0;
    bus.wdata = '0;
  endtask

  // Waits for any grant after req was driven; cycles = edges until it shows.
  task automatic waitGrant(input int limit, output int cycles, output logic [NCH-1:0] seen);
    cycles = 0;
    seen   = '0;
    for (int c = 1; c <= limit; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (bus.gnt !== '0) begin
        cycles = c;
        seen   = bus.gnt;
        break;
      end
    end
  endtask

  // Issues one command on a granted channel and records every rdy beat.
  task automatic runCmd(input int ch, input bit wr, input bit burst, input logic [AW-1:0] a,
                        output int nRdy, output int firstCyc, output int lastCyc,
                        output bit otherRdy);
    nRdy     = 0;
    firstCyc = -1;
    lastCyc  = -1;
    otherRdy = 1'b0;
    @(posedge clk); #1;
    bus.start[ch]             = 1'b1;
    bus.addr[ch*AW +: AW]     = a;
    bus.mode[ch*2 +: 2]       = {burst, wr};
    bus.wdata[ch*DW +: DW]    = wBuf[0];
    for (int cyc = 1; cyc <= BURST_LEN + 2; cyc++) begin
      @(posedge clk); #1;
      bus.start[ch] = 1'b0;
      if (nRdy < 16) bus.wdata[ch*DW +: DW] = wBuf[nRdy];
      @(negedge clk);
      if (bus.rdy[ch] === 1'b1) begin
        if (firstCyc < 0) firstCyc = cyc;
        lastCyc = cyc;
        if (nRdy < 16) rBuf[nRdy] = bus.rdata;
        nRdy++;
      end
      if ((bus.rdy & ~oneHot(ch)) !== '0) otherRdy = 1'b1;
    end
  endtask

  // Drops every request and lets the block pass through RELEASE to IDLE.
  task automatic releaseAll();
    @(posedge clk); #1;
    bus.req = '0;
    repeat (2) @(posedge clk);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clearInputs();
    repeat (3) @(posedge clk);
    @(negedge clk);
    nChecks++; if (bus.gnt !== '0) begin nFails++; $display("[TB] FAIL reset_gnt: got %b, expected 0", bus.gnt); end
    nChecks++; if (bus.rdy !== '0) begin nFails++; $display("[TB] FAIL reset_rdy: got %b, expected 0", bus.rdy); end
    nChecks++; if (bus.rdata !== '0) begin nFails++; $display("[TB] FAIL reset_rdata: got %h, expected 0", bus.rdata); end
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL reset_busy: got %b, expected 0", bus.busy); end
    nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL reset_err: got %b, expected 0", bus.err); end
    @(posedge clk); #1;
    rst     = 1'b0;
    rrModel = 0;
  endtask

  task automatic test_single_rw();
    int cyc, nRdy, firstCyc, lastCyc;
    bit otherRdy;
    logic [NCH-1:0] seen;
    @(posedge clk); #1;
    bus.req[0] = 1'b1;
    waitGrant(8, cyc, seen);
    nChecks++; if (seen !== oneHot(expectedWinner(2'b01))) begin nFails++; $display("[TB] FAIL single_gnt: got %b, expected %b", seen, oneHot(expectedWinner(2'b01))); end
    nChecks++; if (cyc !== 1) begin nFails++; $display("[TB] FAIL single_gnt_latency: got %0d, expected 1", cyc); end
    nChecks++; if (bus.busy !== 1'b1) begin nFails++; $display("[TB] FAIL single_busy: got %b, expected 1", bus.busy); end
    wBuf[0] = 8'hA5;
    runCmd(0, 1'b1, 1'b0, 8'h10, nRdy, firstCyc, lastCyc, otherRdy);
    modelWrite(8'h10, 8'hA5);
    nChecks++; if (nRdy !== 1) begin nFails++; $display("[TB] FAIL single_wr_beats: got %0d, expected 1", nRdy); end
    nChecks++; if (firstCyc !== 1) begin nFails++; $display("[TB] FAIL single_wr_latency: got %0d, expected 1", firstCyc); end
    runCmd(0, 1'b0, 1'b0, 8'h10, nRdy, firstCyc, lastCyc, otherRdy);
    nChecks++; if (rBuf[0] !== memModel[8'h10]) begin nFails++; $display("[TB] FAIL single_rd_data: got %h, expected %h", rBuf[0], memModel[8'h10]); end
    nChecks++; if (firstCyc !== 1) begin nFails++; $display("[TB] FAIL single_rd_latency: got %0d, expected 1", firstCyc); end
    @(negedge clk);
    nChecks++; if (bus.rdata !== memModel[8'h10]) begin nFails++; $display("[TB] FAIL rdata_hold: got %h, expected %h", bus.rdata, memModel[8'h10]); end
    releaseAll();
    rrModel = 1;
  endtask

  task automatic test_burst_wrap();
    int cyc, nRdy, firstCyc, lastCyc;
    bit otherRdy;
    logic [NCH-1:0] seen;
    logic [AW-1:0] a;
    @(posedge clk); #1;
    bus.req[1] = 1'b1;
    waitGrant(8, cyc, seen);
    nChecks++; if (seen !== oneHot(expectedWinner(2'b10))) begin nFails++; $display("[TB] FAIL burst_gnt: got %b, expected %b", seen, oneHot(expectedWinner(2'b10))); end
    wBuf[0] = 8'h11; wBuf[1] = 8'h22; wBuf[2] = 8'h33; wBuf[3] = 8'h44;
    runCmd(1, 1'b1, 1'b1, 8'hFE, nRdy, firstCyc, lastCyc, otherRdy);
    for (int i = 0; i < BURST_LEN; i++) begin
      a = AW'(8'hFE + i);
      modelWrite(a, wBuf[i]);
    end
    nChecks++; if (nRdy !== BURST_LEN) begin nFails++; $display("[TB] FAIL burst_wr_beats: got %0d, expected %0d", nRdy, BURST_LEN); end
    nChecks++; if (lastCyc - firstCyc + 1 !== BURST_LEN) begin nFails++; $display("[TB] FAIL burst_wr_continuous: got %0d, expected %0d", lastCyc - firstCyc + 1, BURST_LEN); end
    nChecks++; if (otherRdy !== 1'b0) begin nFails++; $display("[TB] FAIL burst_other_rdy: got %b, expected 0", otherRdy); end
    runCmd(1, 1'b0, 1'b1, 8'hFE, nRdy, firstCyc, lastCyc, otherRdy);
    nChecks++; if (nRdy !== BURST_LEN) begin nFails++; $display("[TB] FAIL burst_rd_beats: got %0d, expected %0d", nRdy, BURST_LEN); end
    for (int i = 0; i < BURST_LEN; i++) begin
      a = AW'(8'hFE + i);
      nChecks++; if (rBuf[i] !== memModel[a]) begin nFails++; $display("[TB] FAIL burst_rd_data[%0d]: got %h, expected %h", i, rBuf[i], memModel[a]); end
    end
    releaseAll();
    rrModel = 0;
  endtask

  task automatic test_contention();
    int cyc, zeros;
    logic [NCH-1:0] seen;
    rst = 1'b1;
    clearInputs();
    @(posedge clk); #1;
    rst     = 1'b0;
    rrModel = 0;
    bus.req = 2'b11;
    waitGrant(8, cyc, seen);
    nChecks++; if (seen !== oneHot(expectedWinner(2'b11))) begin nFails++; $display("[TB] FAIL contention_first: got %b, expected %b", seen, oneHot(expectedWinner(2'b11))); end
    for (int round = 0; round < 2; round++) begin
      int owner;
      owner = expectedWinner(2'b11);
      @(posedge clk); #1;
      bus.req[owner] = 1'b0;
      @(posedge clk); #1;
      bus.req[owner] = 1'b1;
      rrModel = (owner + 1) % NCH;
      zeros = 0;
      for (int c = 0; c < 8; c++) begin
        @(negedge clk);
        if (bus.gnt !== '0) break;
        zeros++;
      end
      nChecks++; if (zeros !== 2) begin nFails++; $display("[TB] FAIL contention_turnaround[%0d]: got %0d, expected 2", round, zeros); end
      nChecks++; if (bus.gnt !== oneHot(expectedWinner(2'b11))) begin nFails++; $display("[TB] FAIL contention_next[%0d]: got %b, expected %b", round, bus.gnt, oneHot(expectedWinner(2'b11))); end
    end
  endtask

  task automatic test_nongranted_start();
    int nRdy, firstCyc, lastCyc;
    bit otherRdy, strayRdy;
    strayRdy = 1'b0;
    @(posedge clk); #1;
    bus.start[1]       = 1'b1;
    bus.mode[3:2]      = 2'b01;
    bus.addr[15:8]     = 8'h10;
    bus.wdata[15:8]    = 8'h5A;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      if (bus.rdy !== '0) strayRdy = 1'b1;
      @(posedge clk); #1;
    end
    bus.start[1] = 1'b0;
    nChecks++; if (strayRdy !== 1'b0) begin nFails++; $display("[TB] FAIL nongranted_rdy: got %b, expected 0", strayRdy); end
    runCmd(0, 1'b0, 1'b0, 8'h10, nRdy, firstCyc, lastCyc, otherRdy);
    nChecks++; if (rBuf[0] !== memModel[8'h10]) begin nFails++; $display("[TB] FAIL nongranted_mem: got %h, expected %h", rBuf[0], memModel[8'h10]); end
    bus.req[1] = 1'b0;
  endtask

  task automatic test_reset_mid_burst();
    int cyc, nRdy, firstCyc, lastCyc, beats;
    bit otherRdy;
    logic [NCH-1:0] seen;
    for (int i = 0; i < 4; i++) wBuf[i] = DW'(i + 1);
    runCmd(0, 1'b1, 1'b1, 8'h80, nRdy, firstCyc, lastCyc, otherRdy);
    for (int i = 0; i < 4; i++) modelWrite(AW'(8'h80 + i), wBuf[i]);
    @(posedge clk); #1;
    bus.start[0]   = 1'b1;
    bus.mode[1:0]  = 2'b11;
    bus.addr[7:0]  = 8'h80;
    bus.wdata[7:0] = 8'hF0;
    beats = 0;
    for (int b = 0; b < 2; b++) begin
      @(posedge clk); #1;
      bus.start[0]   = 1'b0;
      bus.wdata[7:0] = DW'(8'hF0 + b);
      @(negedge clk);
      if (bus.rdy[0] === 1'b1) beats++;
    end
    modelWrite(8'h80, 8'hF0);
    modelWrite(8'h81, 8'hF1);
    nChecks++; if (beats !== 2) begin nFails++; $display("[TB] FAIL abort_pre_beats: got %0d, expected 2", beats); end
    @(posedge clk); #1;
    bus.wdata[7:0] = 8'hF2;
    rst = 1'b1;
    @(posedge clk); #1;
    bus.wdata[7:0] = 8'hF3;
    bus.req        = '0;
    @(negedge clk);
    nChecks++; if (bus.gnt !== '0) begin nFails++; $display("[TB] FAIL abort_gnt: got %b, expected 0", bus.gnt); end
    nChecks++; if (bus.busy !== 1'b0) begin nFails++; $display("[TB] FAIL abort_busy: got %b, expected 0", bus.busy); end
    nChecks++; if (bus.rdy !== '0) begin nFails++; $display("[TB] FAIL abort_rdy: got %b, expected 0", bus.rdy); end
    @(posedge clk); #1;
    rst     = 1'b0;
    rrModel = 0;
    bus.req[0] = 1'b1;
    waitGrant(8, cyc, seen);
    nChecks++; if (seen !== oneHot(expectedWinner(2'b01))) begin nFails++; $display("[TB] FAIL abort_regrant: got %b, expected %b", seen, oneHot(expectedWinner(2'b01))); end
    runCmd(0, 1'b0, 1'b1, 8'h80, nRdy, firstCyc, lastCyc, otherRdy);
    for (int i = 0; i < 4; i++) begin
      nChecks++; if (rBuf[i] !== memModel[AW'(8'h80 + i)]) begin nFails++; $display("[TB] FAIL abort_mem[%0d]: got %h, expected %h", i, rBuf[i], memModel[AW'(8'h80 + i)]); end
    end
    releaseAll();
    rrModel = 1;
  endtask

  task automatic test_random();
    int cyc, nRdy, firstCyc, lastCyc, ch, nBeats;
    bit otherRdy, wr, burst;
    logic [NCH-1:0] seen, reqs;
    logic [AW-1:0] a, lastWrAddr, ba;
    lastWrAddr = 8'h10;
    for (int t = 0; t < 24; t++) begin
      reqs  = NCH'($urandom_range(1, 2 ** NCH - 1));
      ch    = expectedWinner(reqs);
      wr    = 1'($urandom_range(0, 1));
      burst = 1'($urandom_range(0, 1));
      a     = AW'($urandom);
      if (!wr && ($urandom_range(0, 1) == 1)) a = lastWrAddr;
      for (int i = 0; i < 16; i++) wBuf[i] = DW'($urandom);
      nBeats = burst ? BURST_LEN : 1;
      @(posedge clk); #1;
      bus.req = reqs;
      waitGrant(8, cyc, seen);
      nChecks++; if (seen !== oneHot(ch)) begin nFails++; $display("[TB] FAIL rand_gnt[%0d]: got %b, expected %b", t, seen, oneHot(ch)); end
      runCmd(ch, wr, burst, a, nRdy, firstCyc, lastCyc, otherRdy);
      nChecks++; if (nRdy !== nBeats) begin nFails++; $display("[TB] FAIL rand_beats[%0d]: got %0d, expected %0d", t, nRdy, nBeats); end
      for (int i = 0; i < nBeats; i++) begin
        ba = AW'(a + i);
        if (wr) begin
          modelWrite(ba, wBuf[i]);
          lastWrAddr = a;
        end else if (memKnown[ba]) begin
          nChecks++; if (rBuf[i] !== memModel[ba]) begin nFails++; $display("[TB] FAIL rand_rdata[%0d.%0d]: got %h, expected %h", t, i, rBuf[i], memModel[ba]); end
        end
      end
      releaseAll();
      rrModel = (ch + 1) % NCH;
    end
  endtask

`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
  task automatic test_timeout();
    int cyc, waited;
    bit errSeen;
    logic [NCH-1:0] seen, gntAtErr;
    rst = 1'b1;
    clearInputs();
    @(posedge clk); #1;
    rst     = 1'b0;
    rrModel = 0;
    bus.req = 2'b11;
    waitGrant(8, cyc, seen);
    nChecks++; if (seen !== oneHot(expectedWinner(2'b11))) begin nFails++; $display("[TB] FAIL timeout_gnt: got %b, expected %b", seen, oneHot(expectedWinner(2'b11))); end
    errSeen  = 1'b0;
    gntAtErr = 'x;
    waited   = 0;
    for (int c = 0; c < TIMEOUT + 8; c++) begin
      @(negedge clk);
      waited++;
      if (bus.err === 1'b1) begin
        errSeen  = 1'b1;
        gntAtErr = bus.gnt;
        break;
      end
    end
    nChecks++; if (errSeen !== 1'b1) begin nFails++; $display("[TB] FAIL timeout_err: got %b, expected 1", errSeen); end
    nChecks++; if (waited !== TIMEOUT) begin nFails++; $display("[TB] FAIL timeout_delay: got %0d, expected %0d", waited, TIMEOUT); end
    nChecks++; if (gntAtErr !== '0) begin nFails++; $display("[TB] FAIL timeout_revoke: got %b, expected 0", gntAtErr); end
    rrModel = 1;
    @(negedge clk);
    nChecks++; if (bus.err !== 1'b0) begin nFails++; $display("[TB] FAIL timeout_pulse: got %b, expected 0", bus.err); end
    @(negedge clk);
    nChecks++; if (bus.gnt !== oneHot(expectedWinner(2'b11))) begin nFails++; $display("[TB] FAIL timeout_next: got %b, expected %b", bus.gnt, oneHot(expectedWinner(2'b11))); end
    releaseAll();
  endtask
`endif

  initial begin
    for (int i = 0; i < DEPTH; i++) begin
      memModel[i] = '0;
      memKnown[i] = 1'b0;
    end
    rrModel = 0;
    rst     = 1'b1;
    clearInputs();
    test_reset();
    test_single_rw();
    test_burst_wrap();
    test_contention();
    test_nongranted_start();
    test_reset_mid_burst();
    test_random();
`ifdef SIMPLE_BUS_ARB_TIMEOUT_EN
    test_timeout();
`endif
    $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
    $finish;
  end

  // Hard stop in case a scenario stalls on the bus.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "[TB] time limit");
  end

endmodule
